// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed SRAM; independent single-outstanding read and write FSMs.
// Optional ready/valid stall injection via an LFSR when AXI_SLV_STALL_EN is defined.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_wid,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [8:0]  MaxBeats = 9'(MAX_LEN);
  localparam logic [7:0]  MaxLast  = 8'(MAX_LEN - 1);

  typedef enum logic {RIdle, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [31:0] mem [Depth];

  logic unused_inputs;
  assign unused_inputs = ^{axi_araddr[31:ADDR_WIDTH+2], axi_araddr[1:0], axi_arsize, axi_arburst,
                           axi_awaddr[31:ADDR_WIDTH+2], axi_awaddr[1:0], axi_awsize, axi_wid};

  logic stall_a, stall_r;
`ifdef AXI_SLV_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall_a = lfsr_q[0];
  assign stall_r = lfsr_q[1];
`else
  assign stall_a = 1'b0;
  assign stall_r = 1'b0;
`endif

  // Read channel
  r_state_e              r_state_q, r_state_d;
  logic [3:0]            r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                  r_err_q, r_err_d, r_shown_q, r_shown_d;
  logic [8:0]            ar_beats;

  assign ar_beats  = {1'b0, axi_arlen} + 9'd1;
  assign axi_rdata = mem[r_idx_q];
  assign axi_rid   = r_id_q;
  assign axi_rlast = (r_state_q == RData) && (r_beat_q == r_len_q);
  assign axi_rresp = ((r_state_q == RData) && r_err_q) ? 2'b10 : 2'b00;

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_idx_d     = r_idx_q;
    r_len_d     = r_len_q;
    r_beat_d    = r_beat_q;
    r_err_d     = r_err_q;
    r_shown_d   = r_shown_q;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        axi_arready = ~stall_a;
        if (axi_arvalid && !stall_a) begin
          r_id_d    = axi_arid;
          r_idx_d   = axi_araddr[ADDR_WIDTH+1:2];
          r_beat_d  = 8'd0;
          r_shown_d = 1'b0;
          // Oversized bursts are cut short and flagged on every beat.
          if (ar_beats > MaxBeats) begin
            r_len_d = MaxLast;
            r_err_d = 1'b1;
          end else begin
            r_len_d = axi_arlen;
            r_err_d = 1'b0;
          end
          r_state_d = RData;
        end
      end
      RData: begin
        // Once a beat is shown it stays up regardless of the stall source.
        axi_rvalid = r_shown_q | ~stall_r;
        if (axi_rvalid && axi_rready) begin
          r_idx_d   = r_idx_q + 1'b1;
          r_beat_d  = r_beat_q + 8'd1;
          r_shown_d = 1'b0;
          if (r_beat_q == r_len_q) r_state_d = RIdle;
        end else begin
          r_shown_d = axi_rvalid;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
      r_id_q    <= 4'd0;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      r_err_q   <= 1'b0;
      r_shown_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_err_q   <= r_err_d;
      r_shown_q <= r_shown_d;
    end
  end

  // Write channel
  w_state_e              w_state_q, w_state_d;
  logic [3:0]            w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                  w_err_q, w_err_d, w_fire, w_last_beat;

  assign w_last_beat = (w_beat_q == w_len_q);
  assign w_fire      = (w_state_q == WData) && axi_wvalid && !stall_a && !reset;
  assign axi_bid     = w_id_q;
  assign axi_bresp   = ((w_state_q == WResp) && w_err_q) ? 2'b10 : 2'b00;

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    w_err_d     = w_err_q;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        axi_awready = ~stall_a;
        if (axi_awvalid && !stall_a) begin
          w_id_d    = axi_awid;
          w_idx_d   = axi_awaddr[ADDR_WIDTH+1:2];
          w_len_d   = axi_awlen;
          w_beat_d  = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        axi_wready = ~stall_a;
        if (axi_wvalid && !stall_a) begin
          w_idx_d  = w_idx_q + 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          // Either end marker closes the burst; disagreement is an error.
          if (axi_wlast || w_last_beat) begin
            w_err_d   = axi_wlast != w_last_beat;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        axi_bvalid = 1'b1;
        if (axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
      w_id_q    <= 4'd0;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_beat_q  <= 8'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_wstrb[i]) mem[w_idx_q][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: reference memory model feeds expected-data and
// expected-response queues that are drained as the DUT produces R beats and B responses.
module tb_axi_sram_slave;
  localparam int unsigned AW    = 12;
  localparam int unsigned Depth = 2 ** AW;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  axi_arid, axi_rid, axi_awid, axi_wid, axi_bid;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_rresp, axi_bresp;
  logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(AW), .MAX_LEN(16)) dut (
    .clk(clk), .reset(reset),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wid(axi_wid), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  logic [31:0] model [Depth];
  logic [31:0] rq [$];
  logic [5:0]  bq [$];
  logic [31:0] wd [16];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] strb, input int last_at);
    logic [AW-1:0] idx;
    int n, budget;
    logic [1:0] resp;
    idx  = addr[AW+1:2];
    n    = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    resp = (last_at == int'(len)) ? 2'b00 : 2'b10;
    bq.push_back({id, resp});
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = 3'd2; axi_awvalid = 1'b1;
    budget = 0;
    while (!axi_awready && budget < 50) begin tick(); budget++; end
    if (budget >= 50) check("aw_timeout", budget, 0);
    tick();
    axi_awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      axi_wvalid = 1'b1; axi_wdata = wd[i]; axi_wstrb = strb; axi_wlast = (i == last_at);
      budget = 0;
      while (!axi_wready && budget < 50) begin tick(); budget++; end
      if (budget >= 50) check("w_timeout", budget, 0);
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
      idx++;
      tick();
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    check("bvalid_next", axi_bvalid, 1);
    check("bid_bresp", {axi_bid, axi_bresp}, bq.pop_front());
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check("bvalid_drop", axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input bit toggle);
    logic [AW-1:0] idx;
    int n, got, cyc, budget;
    logic [1:0] resp;
    idx  = addr[AW+1:2];
    n    = (int'(len) + 1 > 16) ? 16 : int'(len) + 1;
    resp = (int'(len) + 1 > 16) ? 2'b10 : 2'b00;
    for (int i = 0; i < n; i++) begin rq.push_back(model[idx]); idx++; end
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = 3'd2; axi_arburst = 2'b01;
    axi_arvalid = 1'b1;
    budget = 0;
    while (!axi_arready && budget < 50) begin tick(); budget++; end
    if (budget >= 50) check("ar_timeout", budget, 0);
    tick();
    axi_arvalid = 1'b0;
    check("rvalid_first", axi_rvalid, 1);
    got = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (axi_rvalid) begin
        // Compared every valid cycle, so a stalled beat must hold its data and rlast.
        check("rdata", axi_rdata, rq[0]);
        check("rlast", axi_rlast, got == n - 1);
        if (axi_rready) begin
          check("rid", axi_rid, id);
          check("rresp", axi_rresp, resp);
          void'(rq.pop_front());
          got++;
        end
      end
      tick();
      cyc++;
    end
    axi_rready = 1'b0;
    if (got < n) check("r_timeout", got, n);
    check("rvalid_idle", axi_rvalid, 0);
  endtask

  initial begin
    reset = 1'b1;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = 2'b01;
    axi_arvalid = 1'b0; axi_rready = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awvalid = 1'b0;
    axi_wid = '0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    tick(); tick(); tick();
    check("rst_arready", axi_arready, 1);
    check("rst_awready", axi_awready, 1);
    check("rst_rvalid", axi_rvalid, 0);
    check("rst_rlast", axi_rlast, 0);
    check("rst_wready", axi_wready, 0);
    check("rst_bvalid", axi_bvalid, 0);
    check("rst_ids", {axi_rid, axi_bid}, 0);
    check("rst_resp", {axi_rresp, axi_bresp}, 0);
    reset = 1'b0;
    tick();

    // 4-beat writeback then line fill of the same words
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_write(4'd1, 32'h100, 8'd3, 4'hF, 3);
    do_read(4'd1, 32'h100, 8'd3, 1'b0);

    // 8-beat read with rready toggling
    for (int i = 0; i < 8; i++) wd[i] = 32'hA000_0000 + 32'(i * 32'h0101);
    do_write(4'd2, 32'h200, 8'd7, 4'hF, 7);
    do_read(4'd0, 32'h200, 8'd7, 1'b1);

    // Narrow single-byte write merged into an existing word
    wd[0] = 32'h2222_2222;
    do_write(4'd3, 32'h104, 8'd0, 4'hF, 0);
    wd[0] = 32'hAABB_CCDD;
    do_write(4'd3, 32'h104, 8'd0, 4'b0010, 0);
    do_read(4'd3, 32'h104, 8'd0, 1'b0);
    check("narrow_merge", model[AW'(32'h41)], 32'h2222_CC22);

    // Burst wrapping past the top of the array, plus an aliased read of index 0
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE_0000 + 32'(i);
    do_write(4'd4, 32'h3FF8, 8'd3, 4'hF, 3);
    do_read(4'd4, 32'h3FF8, 8'd3, 1'b0);
    do_read(4'd5, 32'h0000, 8'd1, 1'b0);
    do_read(4'd5, 32'h4000, 8'd1, 1'b0);

    // Early wlast: only two words change, SLVERR response
    for (int i = 0; i < 4; i++) wd[i] = 32'h5500_0000 + 32'(i);
    do_write(4'd6, 32'h300, 8'd3, 4'hF, 3);
    for (int i = 0; i < 4; i++) wd[i] = 32'h6600_0000 + 32'(i);
    do_write(4'd7, 32'h300, 8'd3, 4'hF, 1);
    do_read(4'd7, 32'h300, 8'd3, 1'b0);

    // Oversized read truncated to 16 beats with SLVERR
    for (int i = 0; i < 16; i++) wd[i] = 32'h7700_0000 + 32'(i);
    do_write(4'd8, 32'h400, 8'd15, 4'hF, 15);
    do_read(4'd9, 32'h400, 8'd17, 1'b0);

    // Reset in the middle of an 8-beat read
    axi_arid = 4'd2; axi_araddr = 32'h200; axi_arlen = 8'd7; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0; axi_rready = 1'b1;
    tick(); tick(); tick();
    check("mid_rvalid", axi_rvalid, 1);
    reset = 1'b1; axi_rready = 1'b0;
    tick();
    check("abort_rvalid", axi_rvalid, 0);
    check("abort_arready", axi_arready, 1);
    reset = 1'b0;
    tick();

    // Concurrent read and write on disjoint regions
    for (int i = 0; i < 4; i++) wd[i] = 32'h8800_0000 + 32'(i);
    fork
      do_write(4'd10, 32'h600, 8'd3, 4'hF, 3);
      do_read(4'd11, 32'h400, 8'd3, 1'b0);
    join
    do_read(4'd12, 32'h600, 8'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
